// File: rtl/hdmi_frame_dma_if.sv
// rtl/hdmi_frame_dma_if.sv - Avalon-MM read master and stream FIFO write-side bundle
interface hdmi_frame_dma_if #(
    parameter int FIFO_AW = 10
) ();
    logic [31:0]        avm_address;
    logic               avm_read;
    logic [7:0]         avm_burstcount;
    logic               avm_waitrequest;
    logic [31:0]        avm_readdata;
    logic               avm_readdatavalid;
    logic               fifo_wrreq;
    logic [23:0]        fifo_wrdata;
    logic [FIFO_AW-1:0] fifo_wrusedw;
    logic               fifo_aclr;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output fifo_wrreq, fifo_wrdata, fifo_aclr,
        input  fifo_wrusedw
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  fifo_wrreq, fifo_wrdata, fifo_aclr,
        output fifo_wrusedw
    );
endinterface

// File: rtl/hdmi_frame_dma.sv
// rtl/hdmi_frame_dma.sv - VSync-aligned frame reader from DDR3 into the HDMI stream FIFO
module hdmi_frame_dma #(
    parameter int H_VISIBLE   = 960,
    parameter int V_VISIBLE   = 540,
    parameter int BURST_LEN   = 32,
    parameter int FIFO_DEPTH  = 1024,
    parameter int FIFO_AW     = 10,
    parameter int FIFO_MARGIN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cont_en,
    input  logic        vs_toggle,
    input  logic [31:0] frame_ptr,
    output logic        busy,
    output logic        done,
    output logic        vs_miss,
    hdmi_frame_dma_if.master bus
);
    localparam logic [19:0] TOTAL_W = 20'(H_VISIBLE * V_VISIBLE);
    localparam logic [19:0] BURST_W = 20'(BURST_LEN);
    localparam logic [21:0] CREDIT  = 22'(FIFO_DEPTH - FIFO_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_FLUSH, S_ISSUE, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [31:0] base_q, base_d;
    logic [19:0] issued_q, issued_d;
    logic [19:0] outstanding_q, outstanding_d;
    logic        avm_read_q, avm_read_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic [7:0]  avm_burstcount_q, avm_burstcount_d;
    logic        fifo_wrreq_q, fifo_wrreq_d;
    logic [23:0] fifo_wrdata_q, fifo_wrdata_d;
    logic        fifo_aclr_q, fifo_aclr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        vs_miss_q, vs_miss_d;

    logic        vs_evt;
    logic        in_xfer;
    logic        accept;
    logic        rd_take;
    logic [19:0] remain;
    logic [19:0] len;
    logic [19:0] bc_ext;
    logic [21:0] need;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^bus.avm_readdata[31:24];

    assign vs_evt  = sync_q[2] ^ sync_q[1];
    assign in_xfer = (state_q == S_FLUSH) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign accept  = avm_read_q & ~bus.avm_waitrequest;
    assign rd_take = bus.avm_readdatavalid & in_xfer;
    assign remain  = TOTAL_W - issued_q;
    assign len     = (remain < BURST_W) ? remain : BURST_W;
    assign bc_ext  = {12'd0, avm_burstcount_q};
    // Credit: words already in the FIFO plus words still in flight plus this burst must fit.
    assign need    = 22'(bus.fifo_wrusedw) + 22'(outstanding_q) + 22'(len);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issued_d         = issued_q;
        outstanding_d    = outstanding_q + (accept ? bc_ext : 20'd0) - (rd_take ? 20'd1 : 20'd0);
        avm_read_d       = avm_read_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        fifo_wrreq_d     = rd_take;
        fifo_wrdata_d    = rd_take ? bus.avm_readdata[23:0] : fifo_wrdata_q;
        fifo_aclr_d      = 1'b0;
        done_d           = 1'b0;
        vs_miss_d        = vs_evt & in_xfer;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_evt) begin
                    base_d        = frame_ptr;
                    issued_d      = 20'd0;
                    outstanding_d = 20'd0;
                    fifo_aclr_d   = 1'b1;
                    state_d       = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    avm_read_d = 1'b0;
                    issued_d   = issued_q + bc_ext;
                    if (issued_q + bc_ext == TOTAL_W) state_d = S_DRAIN;
                end else if (!avm_read_q && remain != 20'd0 && need <= CREDIT) begin
                    avm_read_d       = 1'b1;
                    avm_address_d    = base_q + {10'd0, issued_q, 2'b00};
                    avm_burstcount_d = len[7:0];
                end
            end
            S_DRAIN: begin
                if (outstanding_q == 20'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = cont_en ? S_WAIT_VS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            sync_q           <= 3'b000;
            base_q           <= 32'd0;
            issued_q         <= 20'd0;
            outstanding_q    <= 20'd0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= 32'd0;
            avm_burstcount_q <= 8'd0;
            fifo_wrreq_q     <= 1'b0;
            fifo_wrdata_q    <= 24'd0;
            fifo_aclr_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            vs_miss_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            sync_q           <= {sync_q[1:0], vs_toggle};
            base_q           <= base_d;
            issued_q         <= issued_d;
            outstanding_q    <= outstanding_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            fifo_wrreq_q     <= fifo_wrreq_d;
            fifo_wrdata_q    <= fifo_wrdata_d;
            fifo_aclr_q      <= fifo_aclr_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            vs_miss_q        <= vs_miss_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign vs_miss            = vs_miss_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_burstcount = avm_burstcount_q;
    assign bus.fifo_wrreq     = fifo_wrreq_q;
    assign bus.fifo_wrdata    = fifo_wrdata_q;
    assign bus.fifo_aclr      = fifo_aclr_q;
endmodule

// File: tb/tb_hdmi_frame_dma.sv
// tb/tb_hdmi_frame_dma.sv - directed vector bench for hdmi_frame_dma with a 2-cycle-latency burst slave
module tb_hdmi_frame_dma;
    localparam int H = 16, V = 4, BL = 8, DEPTH = 32, AW = 6, MARGIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic        vs_toggle = 1'b0;
    logic [31:0] frame_ptr = 32'd0;
    logic        busy, done, vs_miss;

    hdmi_frame_dma_if #(.FIFO_AW(AW)) bus ();

    hdmi_frame_dma #(
        .H_VISIBLE(H), .V_VISIBLE(V), .BURST_LEN(BL),
        .FIFO_DEPTH(DEPTH), .FIFO_AW(AW), .FIFO_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cont_en(cont_en),
        .vs_toggle(vs_toggle), .frame_ptr(frame_ptr),
        .busy(busy), .done(done), .vs_miss(vs_miss), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ptr;
        int          stall_burst;
        int          stall_cycles;
        bit          late_vs;
        int          exp_stall;
        int          exp_miss;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    int n_vec = 0, n_bad = 0;
    int cyc_n = 0;
    rd_t rq[$];
    logic [23:0] expq[$];
    logic [31:0] addrs[$];
    int n_acc, n_wr, n_done, n_aclr, n_miss, n_notbusy, n_stall, n_rdcyc;
    int data_err, stab_err, bc_err;
    int stall_burst = -1, stall_left = 0;
    bit prev_rw = 1'b0;
    logic [31:0] prev_a;
    logic [7:0]  prev_b;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[9:2] ^ 8'hFF, a[23:0] ^ 24'h3C5A96};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_acc = 0; n_wr = 0; n_done = 0; n_aclr = 0; n_miss = 0; n_notbusy = 0;
        n_stall = 0; n_rdcyc = 0; data_err = 0; stab_err = 0; bc_err = 0;
        addrs.delete();
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int target);
        int t = 0;
        while (n_done < target && t < 3000) begin
            cyc(1);
            t++;
        end
    endtask

    // Slave and monitor: act just after each rising edge so DUT outputs are settled.
    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (!reset_n) begin
            rq.delete();
            expq.delete();
            bus.avm_readdatavalid = 1'b0;
            bus.avm_waitrequest   = 1'b0;
            prev_rw = 1'b0;
        end else begin
            if (prev_rw && (!bus.avm_read || bus.avm_address !== prev_a || bus.avm_burstcount !== prev_b))
                stab_err++;
            bus.avm_waitrequest = bus.avm_read && stall_left > 0 && n_acc == stall_burst;
            if (bus.avm_waitrequest) begin
                stall_left--;
                n_stall++;
            end
            prev_rw = bus.avm_read && bus.avm_waitrequest;
            prev_a  = bus.avm_address;
            prev_b  = bus.avm_burstcount;
            if (bus.avm_read) n_rdcyc++;

            if (rq.size() > 0 && rq[0].due <= cyc_n) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = rq[0].d;
                void'(rq.pop_front());
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = $urandom;
            end

            if (bus.avm_read && !bus.avm_waitrequest) begin
                addrs.push_back(bus.avm_address);
                n_acc++;
                if (bus.avm_burstcount != 8'(BL)) bc_err++;
                for (int i = 0; i < int'(bus.avm_burstcount); i++) begin
                    logic [31:0] w;
                    w = mem_word(bus.avm_address + 32'(4 * i));
                    rq.push_back('{cyc_n + 2, w});
                    expq.push_back(w[23:0]);
                end
            end

            if (bus.fifo_wrreq) begin
                n_wr++;
                if (expq.size() == 0) data_err++;
                else begin
                    if (expq[0] !== bus.fifo_wrdata) data_err++;
                    void'(expq.pop_front());
                end
            end
            if (done) n_done++;
            if (bus.fifo_aclr) n_aclr++;
            if (vs_miss) n_miss++;
            if (!busy) n_notbusy++;
        end
    end

    vec_t vt[4];

    initial begin
        vt[0] = '{32'h3000_0000, -1, 0, 1'b0, 0, 0, 32'h3000_00E0};
        vt[1] = '{32'h3000_0000,  2, 5, 1'b0, 5, 0, 32'h3000_00E0};
        vt[2] = '{32'h3000_0000, -1, 0, 1'b1, 0, 1, 32'h3000_00E0};
        vt[3] = '{32'hFFFF_FF80, -1, 0, 1'b0, 0, 0, 32'h0000_0060};

        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'd0;
        bus.fifo_wrusedw      = '0;
        clear_stats();

        cyc(3);
        chk("reset_outputs", {busy, done, vs_miss, bus.avm_read, bus.fifo_wrreq, bus.fifo_aclr}, 0);
        chk("reset_addr", bus.avm_address, 0);
        reset_n = 1'b1;
        cyc(3);

        for (int k = 0; k < 4; k++) begin
            clear_stats();
            stall_burst = vt[k].stall_burst;
            stall_left  = vt[k].stall_cycles;
            frame_ptr   = vt[k].ptr;
            pulse_start();
            cyc(3);
            vs_toggle = ~vs_toggle;
            if (vt[k].late_vs) begin
                for (int t = 0; t < 200 && n_acc < 1; t++) cyc(1);
                vs_toggle = ~vs_toggle;
            end
            wait_done(1);
            cyc(4);
            chk($sformatf("v%0d_done", k), n_done, 1);
            chk($sformatf("v%0d_aclr", k), n_aclr, 1);
            chk($sformatf("v%0d_bursts", k), addrs.size(), 8);
            for (int i = 0; i < addrs.size(); i++)
                chk($sformatf("v%0d_addr%0d", k, i), addrs[i], vt[k].ptr + 32'(32 * i));
            if (addrs.size() == 8) chk($sformatf("v%0d_last", k), addrs[7], vt[k].exp_last);
            chk($sformatf("v%0d_bcount", k), bc_err, 0);
            chk($sformatf("v%0d_wrreq", k), n_wr, 64);
            chk($sformatf("v%0d_data", k), data_err, 0);
            chk($sformatf("v%0d_stable", k), stab_err, 0);
            chk($sformatf("v%0d_stall", k), n_stall, vt[k].exp_stall);
            chk($sformatf("v%0d_vsmiss", k), n_miss, vt[k].exp_miss);
            chk($sformatf("v%0d_busy_end", k), busy, 0);
        end

        // Credit gate: 24 used + 8 > 28 blocks; 20 + 8 = 28 is allowed.
        clear_stats();
        frame_ptr = 32'h3000_0000;
        bus.fifo_wrusedw = 6'd24;
        pulse_start();
        cyc(3);
        vs_toggle = ~vs_toggle;
        cyc(30);
        chk("credit_blocked", n_rdcyc, 0);
        bus.fifo_wrusedw = 6'd20;
        for (int t = 0; t < 20 && n_acc < 1; t++) cyc(1);
        chk("credit_issue", n_acc, 1);
        cyc(4);
        chk("credit_hold_2nd", n_acc, 1);
        if (addrs.size() > 0) chk("credit_addr", addrs[0], 32'h3000_0000);
        bus.fifo_wrusedw = 6'd0;
        wait_done(1);
        cyc(4);
        chk("credit_done", n_done, 1);
        chk("credit_wrreq", n_wr, 64);
        chk("credit_data", data_err, 0);

        // Continuous mode with a pointer change, then cont_en dropped mid-frame.
        frame_ptr = 32'h3000_0000;
        cont_en = 1'b1;
        pulse_start();
        cyc(1);
        clear_stats();
        cyc(2);
        vs_toggle = ~vs_toggle;
        wait_done(1);
        frame_ptr = 32'h3010_0000;
        cyc(2);
        vs_toggle = ~vs_toggle;
        cyc(10);
        cont_en = 1'b0;
        wait_done(2);
        chk("cont_busy_held", n_notbusy, 0);
        cyc(4);
        chk("cont_done", n_done, 2);
        chk("cont_bursts", addrs.size(), 16);
        if (addrs.size() == 16) begin
            chk("cont_f1_last", addrs[7], 32'h3000_00E0);
            chk("cont_f2_first", addrs[8], 32'h3010_0000);
            chk("cont_f2_last", addrs[15], 32'h3010_00E0);
        end
        chk("cont_wrreq", n_wr, 128);
        chk("cont_data", data_err, 0);
        chk("cont_busy_end", busy, 0);

        // Asynchronous reset while a burst request is held by waitrequest.
        clear_stats();
        stall_burst = 0;
        stall_left  = 1000;
        frame_ptr = 32'h3000_0000;
        pulse_start();
        cyc(3);
        vs_toggle = ~vs_toggle;
        for (int t = 0; t < 30 && n_rdcyc < 3; t++) cyc(1);
        chk("rst_pre_read", bus.avm_read, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_outputs", {busy, done, vs_miss, bus.avm_read, bus.fifo_wrreq, bus.fifo_aclr}, 0);
        chk("rst_addr", bus.avm_address, 0);
        chk("rst_bcount", bus.avm_burstcount, 0);
        chk("rst_wrdata", bus.fifo_wrdata, 0);
        cyc(2);
        stall_left = 0;
        stall_burst = -1;
        reset_n = 1'b1;
        clear_stats();
        cyc(10);
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_reads", n_rdcyc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
